song_sequencer: RTL

- Sequences note playback for the music player.
- Walks the selected song's entries in the song ROM and hands each {note, duration} to the note player with a one-cycle `new_note` strobe.
- Waits for the note player's `note_done` before fetching the next entry.
- Signals `song_done` to the player control MCU at end of song.
- Sits between the MCU (`play`, `song`, `reset_player`) and the note player datapath.

---
 rtl/song_pkg.sv | 33 +++
 rtl/dffr.sv | 16 +
 rtl/song_rom.sv | 53 +++++
 rtl/song_sequencer.sv | 115 +++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared widths, state encoding and ROM word layout for the song sequencer.
package song_pkg;

   localparam int unsigned NOTE_IDX_W = 5;
   localparam int unsigned NOTE_W     = 6;
   localparam int unsigned DUR_W      = 6;
   localparam int unsigned SONG_W     = 2;
   localparam int unsigned ADDR_W     = SONG_W + NOTE_IDX_W;

   localparam logic [DUR_W-1:0]      END_DUR  = '0;
   localparam logic [NOTE_IDX_W-1:0] IDX_LAST = '1;

   typedef enum logic [2:0] {
      ST_NEXT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EMIT  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   typedef struct packed {
      logic [NOTE_W-1:0] note;
      logic [DUR_W-1:0]  dur;
   } rom_word_t;

   function automatic rom_word_t mk_word(input int unsigned n, input int unsigned d);
      rom_word_t w;
      w.note = NOTE_W'(n);
      w.dur  = DUR_W'(d);
      return w;
   endfunction

endpackage

// File: rtl/dffr.sv
// Resettable D flop cell: synchronous active-high reset to zero.
module dffr #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   always_ff @(posedge i_clk) begin
      if (i_rst) o_q <= '0;
      else       o_q <= i_d;
   end

endmodule

// File: rtl/song_rom.sv
// Song ROM: four songs of 32 {note, duration} entries, synchronous read.
module song_rom
   import song_pkg::*;
(
   input  logic              i_clk,
   input  logic [ADDR_W-1:0] i_addr,
   output rom_word_t         o_data
);

   rom_word_t r_data;

   // Unlisted entries read as end-of-song markers.
   function automatic rom_word_t rom_lookup(input logic [ADDR_W-1:0] a);
      logic [SONG_W-1:0]     s;
      logic [NOTE_IDX_W-1:0] i;
      rom_word_t             w;
      s = a[ADDR_W-1 -: SONG_W];
      i = a[NOTE_IDX_W-1:0];
      w = mk_word(0, 0);
      case (s)
         2'd0: begin
            case (i)
               5'd0:    w = mk_word(12, 8);
               5'd1:    w = mk_word(20, 3);
               default: w = mk_word(0, 0);
            endcase
         end
         2'd1: begin
            case (i)
               5'd0:    w = mk_word(5, 4);
               5'd1:    w = mk_word(7, 2);
               5'd2:    w = mk_word(9, 6);
               default: w = mk_word(0, 0);
            endcase
         end
         2'd2: w = mk_word(32'(i) + 32'd1, 32'(i) + 32'd1);
         2'd3: begin
            case (i)
               5'd0:    w = mk_word(63, 63);
               default: w = mk_word(0, 0);
            endcase
         end
      endcase
      return w;
   endfunction

   always_ff @(posedge i_clk) begin
      r_data <= rom_lookup(i_addr);
   end

   assign o_data = r_data;

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song in ROM, strobing each {note, duration} to the note
// player and waiting for its note_done; pulses song_done at end of song.
module song_sequencer
   import song_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_reset_player,
   input  logic              i_play,
   input  logic [SONG_W-1:0] i_song,
   input  logic              i_note_done,
   output logic [NOTE_W-1:0] o_note,
   output logic [DUR_W-1:0]  o_duration,
   output logic              o_new_note,
   output logic              o_song_done
);

   logic                  w_rst;
   logic [2:0]            r_state_q;
   state_e                w_state;
   state_e                w_state_nxt;
   logic [NOTE_IDX_W-1:0] r_idx;
   logic [NOTE_IDX_W-1:0] w_idx_nxt;
   logic [NOTE_W-1:0]     r_note;
   logic [NOTE_W-1:0]     w_note_nxt;
   logic [DUR_W-1:0]      r_dur;
   logic [DUR_W-1:0]      w_dur_nxt;
   logic                  r_new_note;
   logic                  w_new_note_nxt;
   logic                  r_song_done;
   logic                  w_song_done_nxt;
   logic [ADDR_W-1:0]     w_rom_addr;
   rom_word_t             w_rom_data;

   assign w_rst      = i_reset | i_reset_player;
   assign w_state    = state_e'(r_state_q);
   assign w_rom_addr = {i_song, r_idx};

   song_rom u_rom (
      .i_clk  (i_clk),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   // Next-state, index and output-register inputs.
   always_comb begin
      w_state_nxt = w_state;
      w_idx_nxt   = r_idx;
      w_note_nxt  = r_note;
      w_dur_nxt   = r_dur;
      case (w_state)
         ST_NEXT: begin
            if (i_play) w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            w_note_nxt  = w_rom_data.note;
            w_dur_nxt   = w_rom_data.dur;
            w_state_nxt = (w_rom_data.dur == END_DUR) ? ST_DONE : ST_EMIT;
         end
         ST_EMIT: begin
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (i_note_done) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_idx_nxt   = r_idx + NOTE_IDX_W'(1);
                  w_state_nxt = ST_NEXT;
               end
            end
         end
         ST_DONE: begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_NEXT;
         end
         default: begin
            w_state_nxt = ST_NEXT;
         end
      endcase
      // Strobes are registered copies of the state being entered.
      w_new_note_nxt  = (w_state_nxt == ST_EMIT);
      w_song_done_nxt = (w_state_nxt == ST_DONE);
   end

   dffr #(.W(3)) u_state_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_state_nxt), .o_q (r_state_q)
   );

   dffr #(.W(NOTE_IDX_W)) u_idx_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_idx_nxt), .o_q (r_idx)
   );

   dffr #(.W(NOTE_W)) u_note_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_note_nxt), .o_q (r_note)
   );

   dffr #(.W(DUR_W)) u_dur_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_dur_nxt), .o_q (r_dur)
   );

   dffr #(.W(1)) u_new_note_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_new_note_nxt), .o_q (r_new_note)
   );

   dffr #(.W(1)) u_song_done_ff (
      .i_clk (i_clk), .i_rst (w_rst), .i_d (w_song_done_nxt), .o_q (r_song_done)
   );

   assign o_note      = r_note;
   assign o_duration  = r_dur;
   assign o_new_note  = r_new_note;
   assign o_song_done = r_song_done;

endmodule
